// File: rtl/clk_mon_pkg.sv
// Shared definitions for the two-phase clock monitor: FSM states and parameter defaults.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        EXP_B = 2'd2,
        EXP_A = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TIMEOUT     = 1000;
    localparam int DEF_LOCK_N      = 4;

endpackage

// File: rtl/clk_mon_sync_edge.sv
// Synchronizer plus rising-edge detector; level and rise appear SYNC_STAGES+1 cycles after din.
// No backpressure: free-running, one result per clk.
module sync_edge
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;

    // level is the delayed copy of the last sync stage, so rise lines up with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            level  <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~level;
        end
    end

endmodule

// File: rtl/clk_phase_monitor.sv
// Checks strict A/B alternation of a two-phase clock pair, reports lock, sticky errors and ph_a period.
// Outputs lag the phase inputs by SYNC_STAGES+2 clk cycles; no backpressure.
module clk_phase_monitor
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int LOCK_N      = DEF_LOCK_N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ph_a,
    input  logic             ph_b,
    input  logic             enable,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_overlap,
    output logic             err_order,
    output logic             err_timeout,
    output logic [CNT_W-1:0] period_cnt,
    output logic             period_valid
);

    localparam int               LCK_W    = $clog2(LOCK_N + 1);
    localparam logic [LCK_W-1:0] LOCK_MAX = LCK_W'(LOCK_N);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    logic a_lvl, a_rise, b_lvl, b_rise;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk(clk), .reset(reset), .din(ph_a), .level(a_lvl), .rise(a_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk(clk), .reset(reset), .din(ph_b), .level(b_lvl), .rise(b_rise)
    );

    state_t           state, state_nxt;
    logic [LCK_W-1:0] lock_cnt, lock_nxt, lock_inc;
    logic [CNT_W-1:0] to_cnt, per_cnt;
    logic             have_first;
    logic             overlap, a_ev, b_ev, order_hit, timeout_hit, capture;

    always_comb begin
        overlap     = enable & a_lvl & b_lvl;
        a_ev        = enable & a_rise & ~overlap;
        b_ev        = enable & b_rise & ~overlap;
        lock_inc    = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
        state_nxt   = state;
        lock_nxt    = lock_cnt;
        order_hit   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE:    state_nxt = SEEK;
            SEEK:    if (a_ev) state_nxt = EXP_B;
            EXP_B: begin
                if (b_ev) begin
                    state_nxt = EXP_A;
                    lock_nxt  = lock_inc;
                end else if (a_ev) begin
                    order_hit = 1'b1;
                end
            end
            EXP_A: begin
                if (a_ev) begin
                    state_nxt = EXP_B;
                    lock_nxt  = lock_inc;
                end else if (b_ev) begin
                    order_hit = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // a timely edge in the final waiting cycle beats the timeout
        if ((state == EXP_A || state == EXP_B) && state_nxt == state && to_cnt == TO_LAST) begin
            timeout_hit = 1'b1;
            state_nxt   = SEEK;
        end
        if (overlap || order_hit || timeout_hit)
            lock_nxt = '0;
        if (!enable) begin
            state_nxt = IDLE;
            lock_nxt  = '0;
        end
        capture = a_ev & have_first;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            lock_cnt     <= '0;
            to_cnt       <= '0;
            per_cnt      <= '0;
            have_first   <= 1'b0;
            locked       <= 1'b0;
            err_overlap  <= 1'b0;
            err_order    <= 1'b0;
            err_timeout  <= 1'b0;
            period_cnt   <= '0;
            period_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            lock_cnt     <= lock_nxt;
            locked       <= (lock_nxt == LOCK_MAX);
            period_valid <= capture & (lock_nxt == LOCK_MAX);
            err_overlap  <= overlap     | (err_overlap & ~clear_err);
            err_order    <= order_hit   | (err_order   & ~clear_err);
            err_timeout  <= timeout_hit | (err_timeout & ~clear_err);
            if (!enable) begin
                to_cnt     <= '0;
                per_cnt    <= '0;
                have_first <= 1'b0;
            end else begin
                if (state_nxt != state)
                    to_cnt <= '0;
                else if (state == EXP_A || state == EXP_B)
                    to_cnt <= to_cnt + 1'b1;
                if (a_ev)
                    per_cnt <= '0;
                else if (per_cnt != '1)
                    per_cnt <= per_cnt + 1'b1;
                if (capture)
                    period_cnt <= (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;
                have_first <= timeout_hit ? 1'b0 : (have_first | a_ev);
            end
        end
    end

endmodule

// File: tb/tb_clk_phase_monitor.sv
// Bench for clk_phase_monitor: directed scenarios plus random phase traffic against a reference model.
module tb_clk_phase_monitor;
    import clk_mon_pkg::*;

    localparam int NS   = 2;
    localparam int CW   = 16;
    localparam int TO   = 64;
    localparam int LN   = 4;
    localparam int MAXP = (1 << CW) - 1;

    localparam int M_OFF = 0, M_HUNT = 1, M_WANT_B = 2, M_WANT_A = 3;

    logic clk = 1'b0, reset = 1'b1;
    logic ph_a = 1'b0, ph_b = 1'b0, enable = 1'b0, clear_err = 1'b0;
    logic locked, err_overlap, err_order, err_timeout, period_valid;
    logic [CW-1:0] period_cnt;

    int n_cmp = 0, n_bad = 0, pv_seen = 0;
    bit check_on = 1'b0;

    always #5 clk = ~clk;

    clk_phase_monitor #(.SYNC_STAGES(NS), .CNT_W(CW), .TIMEOUT(TO), .LOCK_N(LN)) dut (
        .clk(clk), .reset(reset), .ph_a(ph_a), .ph_b(ph_b), .enable(enable),
        .clear_err(clear_err), .locked(locked), .err_overlap(err_overlap),
        .err_order(err_order), .err_timeout(err_timeout), .period_cnt(period_cnt),
        .period_valid(period_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model: the synchronizer is a pure delay of NS+1 samples on the input history.
    logic hist_a [0:NS+2];
    logic hist_b [0:NS+2];
    int   mode, streak, waited, since_a;
    bit   seen_a;
    logic m_locked, m_ov, m_or, m_to, m_pv;
    logic [CW-1:0] m_pcnt;

    task automatic model_reset();
        for (int i = 0; i <= NS + 2; i++) begin
            hist_a[i] = 1'b0;
            hist_b[i] = 1'b0;
        end
        mode = M_OFF; streak = 0; waited = 0; since_a = 0; seen_a = 0;
        m_locked = 0; m_ov = 0; m_or = 0; m_to = 0; m_pv = 0; m_pcnt = '0;
    endtask

    task automatic model_step();
        logic la, lb, ra, rb, ov, ea, eb, so, st, cap;
        int old;
        for (int i = NS + 2; i > 0; i--) begin
            hist_a[i] = hist_a[i-1];
            hist_b[i] = hist_b[i-1];
        end
        hist_a[0] = ph_a;
        hist_b[0] = ph_b;
        la = hist_a[NS+1]; lb = hist_b[NS+1];
        ra = la & ~hist_a[NS+2]; rb = lb & ~hist_b[NS+2];
        ov = 0; so = 0; st = 0; cap = 0;
        if (!enable) begin
            mode = M_OFF; streak = 0; waited = 0; since_a = 0; seen_a = 0;
        end else begin
            ov = la & lb;
            ea = ra & ~ov;
            eb = rb & ~ov;
            old = mode;
            if (mode == M_OFF) mode = M_HUNT;
            else if (mode == M_HUNT) begin
                if (ea) mode = M_WANT_B;
            end else if (mode == M_WANT_B) begin
                if (eb) begin mode = M_WANT_A; streak++; end
                else if (ea) so = 1;
            end else begin
                if (ea) begin mode = M_WANT_B; streak++; end
                else if (eb) so = 1;
            end
            if (streak > LN) streak = LN;
            if (mode != old) waited = 0;
            else if (mode == M_WANT_A || mode == M_WANT_B) begin
                waited++;
                if (waited == TO) begin st = 1; mode = M_HUNT; waited = 0; end
            end
            if (ov || so || st) streak = 0;
            if (ea) begin
                if (seen_a) begin
                    cap = 1;
                    m_pcnt = CW'((since_a >= MAXP) ? MAXP : since_a + 1);
                end
                since_a = 0;
                seen_a = 1;
            end else if (since_a < MAXP) since_a++;
            if (st) seen_a = 0;
        end
        m_locked = (streak == LN);
        m_pv = cap & m_locked;
        m_ov = ov | (m_ov & ~clear_err);
        m_or = so | (m_or & ~clear_err);
        m_to = st | (m_to & ~clear_err);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (period_valid === 1'b1) pv_seen++;
        if (check_on) begin
            chk("cycle_flags", {locked, err_overlap, err_order, err_timeout, period_valid},
                {m_locked, m_ov, m_or, m_to, m_pv});
            chk("cycle_period", period_cnt, m_pcnt);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ph(input logic a, input logic b, input int n);
        ph_a = a;
        ph_b = b;
        cyc(n);
    endtask

    task automatic period(input int ha, input int hb);
        set_ph(1'b1, 1'b0, ha);
        set_ph(1'b0, 1'b1, hb);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        cyc(1);
        clear_err = 1'b0;
    endtask

    initial begin
        int n, pv0, r, ha, hb;
        cyc(2);
        chk("rst_locked", locked, 0);
        chk("rst_errs", {err_overlap, err_order, err_timeout}, 0);
        chk("rst_period", period_cnt, 0);
        chk("rst_pvalid", period_valid, 0);
        chk("rst_state", dut.state, IDLE);
        check_on = 1'b1;
        reset = 1'b0;
        cyc(2);
        enable = 1'b1;

        // clean 80 ns two-phase clock
        repeat (6) period(8, 8);
        chk("clean_locked", locked, 1);
        chk("clean_period", period_cnt, 16);
        chk("clean_errs", {err_overlap, err_order, err_timeout}, 0);
        pv0 = pv_seen;
        repeat (3) period(8, 8);
        chk("clean_pv_count", pv_seen - pv0, 3);

        // overlap while locked, then relock with the sticky flag still up
        set_ph(1'b1, 1'b0, 4);
        set_ph(1'b1, 1'b1, 3);
        set_ph(1'b1, 1'b0, 4);
        chk("ovl_set", err_overlap, 1);
        chk("ovl_unlock", locked, 0);
        set_ph(1'b0, 1'b1, 8);
        repeat (3) period(8, 8);
        chk("ovl_relock", locked, 1);
        chk("ovl_sticky", err_overlap, 1);
        pulse_clear();
        chk("ovl_cleared", err_overlap, 0);

        // missing ph_b pulse
        set_ph(1'b1, 1'b0, 8);
        set_ph(1'b0, 1'b0, 8);
        set_ph(1'b1, 1'b0, 8);
        chk("order_set", err_order, 1);
        chk("order_unlock", locked, 0);
        chk("order_no_to", err_timeout, 0);
        set_ph(1'b0, 1'b1, 8);
        pulse_clear();

        // ph_b held low after lock
        repeat (5) period(8, 8);
        chk("to_prelock", locked, 1);
        ph_a = 1'b1;
        ph_b = 1'b0;
        n = 0;
        while (err_timeout !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 8) ph_a = 1'b0;
        end
        chk("to_latency", n, TO + NS + 2);
        chk("to_state_seek", dut.state, SEEK);
        chk("to_unlock", locked, 0);
        pulse_clear();

        // reset pulse mid-lock
        repeat (5) period(8, 8);
        chk("rst_prelock", locked, 1);
        set_ph(1'b1, 1'b0, 4);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_outs", {locked, err_overlap, err_order, err_timeout, period_valid}, 0);
        chk("rst_mid_period", period_cnt, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        set_ph(1'b1, 1'b0, 3);
        set_ph(1'b0, 1'b1, 8);
        period(8, 8);
        chk("rst_relock_early", locked, 0);
        set_ph(1'b1, 1'b0, 8);
        chk("rst_relock", locked, 1);

        // clear coinciding with a fresh overlap
        set_ph(1'b0, 1'b1, 4);
        set_ph(1'b1, 1'b1, 1);
        set_ph(1'b0, 1'b1, 2);
        clear_err = 1'b1;
        cyc(1);
        chk("ovl_set_wins", err_overlap, 1);
        cyc(1);
        clear_err = 1'b0;
        chk("ovl_clear_alone", err_overlap, 0);

        // random traffic with occasional faults
        repeat (150) begin
            r  = $urandom_range(0, 99);
            ha = $urandom_range(3, 12);
            hb = $urandom_range(3, 12);
            if (r < 8) begin
                set_ph(1'b1, 1'b0, ha);
                set_ph(1'b0, 1'b0, hb);
            end else if (r < 16) begin
                set_ph(1'b1, 1'b0, ha);
                set_ph(1'b1, 1'b1, $urandom_range(1, 3));
                set_ph(1'b0, 1'b1, hb);
            end else if (r < 20) begin
                enable = 1'b0;
                set_ph(1'b0, 1'b0, $urandom_range(1, 5));
                enable = 1'b1;
            end else if (r < 25) begin
                pulse_clear();
            end else if (r < 28) begin
                set_ph(1'b0, 1'b0, $urandom_range(58, 72));
            end else if (r < 35) begin
                set_ph(1'b1, 1'b0, ha);
                set_ph(1'b0, 1'b0, $urandom_range(1, 3));
                set_ph(1'b0, 1'b1, hb);
            end else begin
                period(ha, hb);
            end
        end
        cyc(4);
        check_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_phase_monitor.md
CLK_PHASE_MONITOR -- requirements
Module: clk_phase_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for each phase input (min 2).
REQ-002 SHALL have parameter CNT_W, default 16, width of period and timeout counters.
REQ-003 SHALL have parameter TIMEOUT, default 1000, max clk cycles allowed between consecutive expected phase rising edges.
REQ-004 SHALL have parameter LOCK_N, default 4, consecutive correct alternations required to assert locked.
REQ-005 clk  input  1  free-running sampling clock, asynchronous to the phase inputs, >=4x the phase toggle rate.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 ph_a  input  1  first phase clock of the two-phase pair (asynchronous).
REQ-008 ph_b  input  1  second phase clock of the two-phase pair (asynchronous).
REQ-009 enable  input  1  monitor enable, synchronous to clk.
REQ-010 clear_err  input  1  one-cycle pulse, clears sticky error flags.
REQ-011 locked  output  1  valid alternation established.
REQ-012 err_overlap  output  1  sticky, both phases high in the same sample.
REQ-013 err_order  output  1  sticky, same phase rose twice without the other phase rising in between.
REQ-014 err_timeout  output  1  sticky, expected edge missing for TIMEOUT cycles.
REQ-015 period_cnt  output  CNT_W  clk cycles between the last two ph_a rising edges.
REQ-016 period_valid  output  1  one-cycle strobe; period_cnt updated this cycle.

Function
REQ-017 Each phase SHALL pass an SYNC_STAGES flop synchronizer, then a rising-edge detector; edge visible SYNC_STAGES+1 clk cycles after the input rises.
REQ-018 FSM states SHALL be IDLE, SEEK, EXP_B, EXP_A.
REQ-019 IDLE: entered when enable=0; SHALL clear locked, lock counter, timeout counter and period counter; sticky errors SHALL be held.
REQ-020 IDLE->SEEK when enable=1; SEEK->EXP_B on a ph_a rise; a ph_b rise in SEEK SHALL be ignored.
REQ-021 EXP_B: ph_b rise -> EXP_A, lock counter +1; ph_a rise -> err_order set, lock counter cleared, remain EXP_B.
REQ-022 EXP_A: ph_a rise -> EXP_B, lock counter +1; ph_b rise -> err_order set, lock counter cleared, remain EXP_A.
REQ-023 Lock counter SHALL saturate at LOCK_N; locked=1 when counter==LOCK_N, cleared the cycle any error is set.
REQ-024 Synchronized ph_a and ph_b both high in the same cycle SHALL set err_overlap and clear the lock counter; rises detected in that cycle SHALL NOT advance the FSM.
REQ-025 Timeout counter SHALL reset on every state change, count in EXP_A/EXP_B, and on reaching TIMEOUT set err_timeout, clear the lock counter, go to SEEK.
REQ-026 Period counter SHALL count clk cycles since the last ph_a rise, saturating at 2^CNT_W-1; on each ph_a rise after the first since SEEK entry, period_cnt <= count+1, counter restarts.
REQ-027 period_valid SHALL pulse only when the period is captured and locked=1 on that cycle.
REQ-028 Sticky errors SHALL clear on clear_err; when set and clear coincide, set SHALL win.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 On reset: FSM=IDLE; synchronizers, edge history, all counters=0; locked=0, all err_*=0, period_cnt=0, period_valid=0.
REQ-031 Reset asserted mid-operation SHALL take effect immediately; after release the monitor re-acquires from SEEK, requiring LOCK_N alternations again.

Structure
REQ-032 Package clk_mon_pkg SHALL hold the FSM state enum and the parameter defaults.
REQ-033 Sub-module sync_edge (synchronizer + rising-edge detector, parameter SYNC_STAGES) SHALL be instantiated once per phase.

Verification
REQ-034 clk 10 ns; phase generator with 80 ns input clock (ph_a/ph_b each 160 ns period, alternate halves), enable=1 -> locked=1 after 4 alternations, period_cnt=16 with period_valid each ph_a rise, no errors.
REQ-035 Force ph_a and ph_b high together for 30 ns while locked -> err_overlap=1, locked=0 next cycle, re-lock after 4 clean alternations, err_overlap stays 1 until clear_err.
REQ-036 Suppress one ph_b pulse (two ph_a rises back-to-back) -> err_order=1, locked=0; err_timeout stays 0.
REQ-037 TIMEOUT=64, hold ph_b low after lock -> err_timeout=1 exactly 64 cycles after entering EXP_B, FSM=SEEK.
REQ-038 Assert reset mid-lock for 1 cycle -> all outputs 0 immediately; after release locked returns only after 4 alternations.
REQ-039 clear_err in the same cycle as a new overlap -> err_overlap remains 1; clear_err alone next cycle -> 0.
